// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: instruction formats, opcode constants and the
// decoded bundle carried from the decode stage to issue.
package riscv_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    ITYPE_I  = 3'd0,
    ITYPE_U  = 3'd1,
    ITYPE_S  = 3'd2,
    ITYPE_R  = 3'd3,
    ITYPE_SB = 3'd4,
    ITYPE_UJ = 3'd5
  } itype_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMM32  = 7'h1B;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_OP32   = 7'h3B;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // pc and imm are sized for the widest datapath; narrower builds use the low bits
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [6:0]          funct7;
    itype_e              itype;
    logic [XLEN_MAX-1:0] imm;
    logic                rs1Used;
    logic                rs2Used;
    logic                rdWe;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and issue-side handshake bundle of the decode stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [2:0]      out_itype;
  logic [XLEN-1:0] out_imm;
  logic            out_rs1_used;
  logic            out_rs2_used;
  logic            out_rd_we;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
           out_rs1, out_rs2, out_funct7, out_itype, out_imm,
           out_rs1_used, out_rs2_used, out_rd_we, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
           out_rs1, out_rs2, out_funct7, out_itype, out_imm,
           out_rs1_used, out_rs2_used, out_rd_we, out_illegal
  );

endinterface

// File: rtl/imm_gen.sv
// Immediate generator: reassembles the scattered immediate bits of each
// instruction format and sign-extends the result to XLEN.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  itype_e          i_itype,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_itype)
      ITYPE_I:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      ITYPE_S:  w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      ITYPE_SB: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
      ITYPE_U:  w_imm32 = {i_instr[31:12], 12'b0};
      ITYPE_UJ: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
      default:  w_imm32 = '0;
    endcase
  end

  // Every format's immediate fits in 32 bits, so widening is a plain sign extension
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// RISC-V decode stage: classifies each instruction, builds the decoded bundle
// and holds it in a main/skid register pair so in_ready comes from a flop.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave bus
);

  logic [6:0]      w_opcode;
  itype_e          w_rawItype;
  logic            w_known;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;
  decoded_t        w_decoded;

  decoded_t        r_main;
  decoded_t        r_skid;
  logic            r_mainValid;
  logic            r_skidValid;
  logic            r_inReady;

  logic            w_accept;
  logic            w_drain;
  logic            w_loadMainIn;
  logic            w_loadMainSkid;
  logic            w_loadSkid;
  logic            w_mainValidNext;
  logic            w_skidValidNext;

  assign w_opcode = bus.in_instr[6:0];

  always_comb begin
    w_rawItype = ITYPE_I;
    w_known    = 1'b1;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR: w_rawItype = ITYPE_I;
      OP_IMM32: begin
        w_rawItype = ITYPE_I;
        w_known    = (XLEN == 64);
      end
      OP_AUIPC, OP_LUI: w_rawItype = ITYPE_U;
      OP_STORE:         w_rawItype = ITYPE_S;
      OP_OP:            w_rawItype = ITYPE_R;
      OP_OP32: begin
        w_rawItype = ITYPE_R;
        w_known    = (XLEN == 64);
      end
      OP_BRANCH:        w_rawItype = ITYPE_SB;
      OP_JAL:           w_rawItype = ITYPE_UJ;
      default:          w_known    = 1'b0;
    endcase
    w_illegal = !w_known || (bus.in_instr[1:0] != 2'b11);
  end

  imm_gen #(
    .XLEN(XLEN)
  ) u_immGen (
    .i_instr(bus.in_instr),
    .i_itype(w_rawItype),
    .o_imm  (w_imm)
  );

  // Illegal encodings keep their raw fields but look like a harmless I-type
  always_comb begin
    w_decoded         = '0;
    w_decoded.pc      = XLEN_MAX'(bus.in_pc);
    w_decoded.opcode  = w_opcode;
    w_decoded.rd      = bus.in_instr[11:7];
    w_decoded.funct3  = bus.in_instr[14:12];
    w_decoded.rs1     = bus.in_instr[19:15];
    w_decoded.rs2     = bus.in_instr[24:20];
    w_decoded.funct7  = bus.in_instr[31:25];
    w_decoded.itype   = w_illegal ? ITYPE_I : w_rawItype;
    w_decoded.imm     = w_illegal ? '0 : XLEN_MAX'(w_imm);
    w_decoded.illegal = w_illegal;
    if (!w_illegal) begin
      case (w_rawItype)
        ITYPE_I: begin
          w_decoded.rs1Used = 1'b1;
          w_decoded.rdWe    = (bus.in_instr[11:7] != 5'd0);
        end
        ITYPE_U:  w_decoded.rdWe = (bus.in_instr[11:7] != 5'd0);
        ITYPE_S, ITYPE_SB: begin
          w_decoded.rs1Used = 1'b1;
          w_decoded.rs2Used = 1'b1;
        end
        ITYPE_R: begin
          w_decoded.rs1Used = 1'b1;
          w_decoded.rs2Used = 1'b1;
          w_decoded.rdWe    = (bus.in_instr[11:7] != 5'd0);
        end
        ITYPE_UJ: w_decoded.rdWe = (bus.in_instr[11:7] != 5'd0);
        default:  w_decoded.rdWe = 1'b0;
      endcase
    end
  end

  // A flushed cycle never accepts, even when in_ready is high
  assign w_accept = bus.in_valid && r_inReady && !flush;
  assign w_drain  = r_mainValid && bus.out_ready;

  always_comb begin
    w_loadMainIn    = 1'b0;
    w_loadMainSkid  = 1'b0;
    w_loadSkid      = 1'b0;
    w_mainValidNext = r_mainValid;
    w_skidValidNext = r_skidValid;
    if (flush) begin
      w_mainValidNext = 1'b0;
      w_skidValidNext = 1'b0;
    end else if (!r_mainValid || w_drain) begin
      if (r_skidValid) begin
        w_loadMainSkid  = 1'b1;
        w_mainValidNext = 1'b1;
        w_skidValidNext = 1'b0;
      end else if (w_accept) begin
        w_loadMainIn    = 1'b1;
        w_mainValidNext = 1'b1;
      end else begin
        w_mainValidNext = 1'b0;
      end
    end else if (w_accept) begin
      w_loadSkid      = 1'b1;
      w_skidValidNext = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      r_mainValid <= w_mainValidNext;
      r_skidValid <= w_skidValidNext;
      r_inReady   <= !w_skidValidNext;
      if (w_loadMainSkid) begin
        r_main <= r_skid;
      end else if (w_loadMainIn) begin
        r_main <= w_decoded;
      end
      if (w_loadSkid) begin
        r_skid <= w_decoded;
      end
    end
  end

  assign bus.in_ready     = r_inReady;
  assign bus.out_valid    = r_mainValid;
  assign bus.out_pc       = r_main.pc[XLEN-1:0];
  assign bus.out_opcode   = r_main.opcode;
  assign bus.out_rd       = r_main.rd;
  assign bus.out_funct3   = r_main.funct3;
  assign bus.out_rs1      = r_main.rs1;
  assign bus.out_rs2      = r_main.rs2;
  assign bus.out_funct7   = r_main.funct7;
  assign bus.out_itype    = r_main.itype;
  assign bus.out_imm      = r_main.imm[XLEN-1:0];
  assign bus.out_rs1_used = r_main.rs1Used;
  assign bus.out_rs2_used = r_main.rs2Used;
  assign bus.out_rd_we    = r_main.rdWe;
  assign bus.out_illegal  = r_main.illegal;

endmodule
